// File: rtl/alu_rs_pkg.sv
// Shared types and defaults for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned RS_SIZE_DEF = 16;
  localparam int unsigned ROB_W_DEF   = 4;
  localparam int unsigned OP_W_DEF    = 6;

  // ALU opcode encodings used by dispatch
  localparam logic [5:0] ALU_ADD   = 6'd0;
  localparam logic [5:0] ALU_SUB   = 6'd1;
  localparam logic [5:0] ALU_ADDI  = 6'd2;
  localparam logic [5:0] ALU_BEQ   = 6'd3;
  localparam logic [5:0] ALU_JALR  = 6'd4;
  localparam logic [5:0] ALU_LSADR = 6'd5;

  // Where an operand's value comes from this cycle
  typedef enum logic [1:0] {
    SRC_HELD = 2'd0,  // already valid in the entry / dispatch payload
    SRC_ALU  = 2'd1,  // forwarded from the ALU result bus
    SRC_LSB  = 2'd2,  // forwarded from the load result bus
    SRC_WAIT = 2'd3   // still pending
  } opnd_src_e;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index priority encoder: reports whether any request is set and
// the index of the lowest one.
module rs_pick #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan upward, keeping the first hit
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = W'(i);
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Reservation station for the integer ALU: buffers dispatched ops, wakes
// operands from the ALU/LSB result buses and issues one ready op per cycle.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned ROB_W   = ROB_W_DEF,
  parameter int unsigned OP_W    = OP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             DP_sgn,
  input  logic [OP_W-1:0]  DP_opcode,
  input  logic [ROB_W-1:0] DP_ROB_name,
  input  logic [31:0]      DP_Vj,
  input  logic [31:0]      DP_Vk,
  input  logic             DP_Qj_busy,
  input  logic             DP_Qk_busy,
  input  logic [ROB_W-1:0] DP_Qj,
  input  logic [ROB_W-1:0] DP_Qk,
  output logic             RS_full,
  input  logic             ALU_CDB_sgn,
  input  logic [31:0]      ALU_CDB_result,
  input  logic [ROB_W-1:0] ALU_CDB_ROB_name,
  input  logic             LSB_CDB_sgn,
  input  logic [31:0]      LSB_CDB_result,
  input  logic [ROB_W-1:0] LSB_CDB_ROB_name,
  input  logic             ROB_clear,
  output logic             ALU_sgn,
  output logic [OP_W-1:0]  ALU_opcode,
  output logic [ROB_W-1:0] ALU_ROB_name,
  output logic [31:0]      ALU_lhs,
  output logic [31:0]      ALU_rhs
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  // Entry state
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] qj_busy;
  logic [RS_SIZE-1:0] qk_busy;
  logic [OP_W-1:0]    op  [RS_SIZE];
  logic [ROB_W-1:0]   rob [RS_SIZE];
  logic [ROB_W-1:0]   qj  [RS_SIZE];
  logic [ROB_W-1:0]   qk  [RS_SIZE];
  logic [31:0]        vj  [RS_SIZE];
  logic [31:0]        vk  [RS_SIZE];

  // Per-entry operand resolution
  opnd_src_e          j_src [RS_SIZE];
  opnd_src_e          k_src [RS_SIZE];
  logic [31:0]        j_fwd [RS_SIZE];
  logic [31:0]        k_fwd [RS_SIZE];
  logic [RS_SIZE-1:0] j_hit;
  logic [RS_SIZE-1:0] k_hit;
  logic [RS_SIZE-1:0] free_req;
  logic [RS_SIZE-1:0] ready_req;

  // Dispatch operand resolution
  opnd_src_e   dj_src;
  opnd_src_e   dk_src;
  logic [31:0] dp_vj;
  logic [31:0] dp_vk;

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             ready_found;
  logic [IDX_W-1:0] ready_idx;
  logic             dp_take;
  logic [CNT_W-1:0] free_pre;
  logic [CNT_W-1:0] free_post;
  logic             full_next;

  // LSB bus wins a tag tie; the tie itself is illegal and asserted below
  function automatic opnd_src_e src_of(
    input logic             pend,
    input logic [ROB_W-1:0] tag,
    input logic             a_sgn,
    input logic [ROB_W-1:0] a_tag,
    input logic             l_sgn,
    input logic [ROB_W-1:0] l_tag
  );
    if (!pend)                  return SRC_HELD;
    if (l_sgn && l_tag == tag)  return SRC_LSB;
    if (a_sgn && a_tag == tag)  return SRC_ALU;
    return SRC_WAIT;
  endfunction

  // Wakeup/readiness for every entry, with CDB forwarding
  always_comb begin
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      j_src[i] = src_of(qj_busy[i], qj[i], ALU_CDB_sgn, ALU_CDB_ROB_name,
                        LSB_CDB_sgn, LSB_CDB_ROB_name);
      k_src[i] = src_of(qk_busy[i], qk[i], ALU_CDB_sgn, ALU_CDB_ROB_name,
                        LSB_CDB_sgn, LSB_CDB_ROB_name);
      case (j_src[i])
        SRC_ALU: j_fwd[i] = ALU_CDB_result;
        SRC_LSB: j_fwd[i] = LSB_CDB_result;
        default: j_fwd[i] = vj[i];
      endcase
      case (k_src[i])
        SRC_ALU: k_fwd[i] = ALU_CDB_result;
        SRC_LSB: k_fwd[i] = LSB_CDB_result;
        default: k_fwd[i] = vk[i];
      endcase
      j_hit[i]     = busy[i] && (j_src[i] == SRC_ALU || j_src[i] == SRC_LSB);
      k_hit[i]     = busy[i] && (k_src[i] == SRC_ALU || k_src[i] == SRC_LSB);
      free_req[i]  = !busy[i];
      ready_req[i] = busy[i] && (j_src[i] != SRC_WAIT) && (k_src[i] != SRC_WAIT);
    end
  end

  // Dispatch-cycle capture of operands already on a result bus
  always_comb begin
    dj_src = src_of(DP_Qj_busy, DP_Qj, ALU_CDB_sgn, ALU_CDB_ROB_name,
                    LSB_CDB_sgn, LSB_CDB_ROB_name);
    dk_src = src_of(DP_Qk_busy, DP_Qk, ALU_CDB_sgn, ALU_CDB_ROB_name,
                    LSB_CDB_sgn, LSB_CDB_ROB_name);
    case (dj_src)
      SRC_ALU: dp_vj = ALU_CDB_result;
      SRC_LSB: dp_vj = LSB_CDB_result;
      default: dp_vj = DP_Vj;
    endcase
    case (dk_src)
      SRC_ALU: dp_vk = ALU_CDB_result;
      SRC_LSB: dp_vk = LSB_CDB_result;
      default: dp_vk = DP_Vk;
    endcase
  end

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_free_pick (
    .req   (free_req),
    .found (free_found),
    .idx   (free_idx)
  );

  rs_pick #(.N(RS_SIZE), .W(IDX_W)) u_ready_pick (
    .req   (ready_req),
    .found (ready_found),
    .idx   (ready_idx)
  );

  // Post-edge free count drives the registered full flag
  always_comb begin
    dp_take  = DP_sgn && free_found;
    free_pre = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      free_pre = free_pre + CNT_W'(free_req[i]);
    end
    free_post = free_pre - CNT_W'(dp_take) + CNT_W'(ready_found);
    full_next = (free_post <= CNT_W'(1));
  end

  // Control state and issue registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= '0;
      qj_busy      <= '0;
      qk_busy      <= '0;
      RS_full      <= 1'b0;
      ALU_sgn      <= 1'b0;
      ALU_opcode   <= '0;
      ALU_ROB_name <= '0;
      ALU_lhs      <= '0;
      ALU_rhs      <= '0;
    end else if (rdy) begin
      if (ROB_clear) begin
        busy    <= '0;
        qj_busy <= '0;
        qk_busy <= '0;
        RS_full <= 1'b0;
        ALU_sgn <= 1'b0;
      end else begin
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
          if (j_hit[i]) qj_busy[i] <= 1'b0;
          if (k_hit[i]) qk_busy[i] <= 1'b0;
        end
        if (ready_found) begin
          busy[ready_idx] <= 1'b0;
          ALU_sgn         <= 1'b1;
          ALU_opcode      <= op[ready_idx];
          ALU_ROB_name    <= rob[ready_idx];
          ALU_lhs         <= j_fwd[ready_idx];
          ALU_rhs         <= k_fwd[ready_idx];
        end else begin
          ALU_sgn <= 1'b0;
        end
        // The allocated slot was free pre-edge, so it never collides with the issued one
        if (dp_take) begin
          busy[free_idx]    <= 1'b1;
          qj_busy[free_idx] <= (dj_src == SRC_WAIT);
          qk_busy[free_idx] <= (dk_src == SRC_WAIT);
        end
        RS_full <= full_next;
      end
    end
  end

  // Entry payload: operand capture on wakeup and write on dispatch
  always_ff @(posedge clk) begin
    if (rdy && !ROB_clear) begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (j_hit[i]) vj[i] <= j_fwd[i];
        if (k_hit[i]) vk[i] <= k_fwd[i];
      end
      if (dp_take) begin
        op[free_idx]  <= DP_opcode;
        rob[free_idx] <= DP_ROB_name;
        qj[free_idx]  <= DP_Qj;
        qk[free_idx]  <= DP_Qk;
        vj[free_idx]  <= dp_vj;
        vk[free_idx]  <= dp_vk;
      end
    end
  end

  a_cdb_tag_unique: assert property (@(posedge clk) disable iff (rst)
    (rdy && ALU_CDB_sgn && LSB_CDB_sgn) |-> (ALU_CDB_ROB_name != LSB_CDB_ROB_name))
    else $error("alu_rs: both result buses carry the same ROB tag");

  a_dispatch_has_room: assert property (@(posedge clk) disable iff (rst)
    (rdy && !ROB_clear && DP_sgn) |-> free_found)
    else $error("alu_rs: dispatch with no free entry dropped");

endmodule

// File: doc/alu_rs.md
# alu_rs

Reservation station and issue scheduler for the integer ALU. It buffers dispatched ALU-class instructions (arithmetic, branch compare, JALR, load/store address) with up to two pending operands. It captures operand values from the ALU and LSB result buses and issues at most one ready instruction per cycle to the combinational ALU through registered outputs. It sits between the decoder/dispatcher and the ALU, and is flushed by the ROB on mispredict.

## Interface
- `RS_SIZE`, 16, number of entries (power of two, ≥4)
- `ROB_W`, 4, ROB tag width (matches `` `ROBID ``)
- `OP_W`, 6, opcode width (matches ALU opcode encoding)

- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `rdy` in 1: global enable; low freezes all state
- `DP_sgn` in 1: dispatch valid
- `DP_opcode` in `OP_W`: ALU opcode
- `DP_ROB_name` in `ROB_W`: destination ROB tag
- `DP_Vj`, `DP_Vk` in 32: operand values (valid when matching Q not pending)
- `DP_Qj_busy`, `DP_Qk_busy` in 1: operand pending
- `DP_Qj`, `DP_Qk` in `ROB_W`: producer tag of pending operand
- `RS_full` out 1: registered; dispatcher must not assert `DP_sgn` while high
- `ALU_CDB_sgn` in 1, `ALU_CDB_result` in 32, `ALU_CDB_ROB_name` in `ROB_W`: ALU result bus
- `LSB_CDB_sgn` in 1, `LSB_CDB_result` in 32, `LSB_CDB_ROB_name` in `ROB_W`: load result bus
- `ROB_clear` in 1: flush (mispredict)
- `ALU_sgn` out 1: issue valid
- `ALU_opcode` out `OP_W`, `ALU_ROB_name` out `ROB_W`, `ALU_lhs` out 32, `ALU_rhs` out 32: registered issue payload

## Operation
- Entry fields: `busy`, `op`, `rob`, `Vj`, `Qj`, `Qj_busy`, `Vk`, `Qk`, `Qk_busy`.
- **Dispatch.** `DP_sgn` writes to the lowest-index free entry. A pending operand whose tag matches either CDB in the same cycle is stored as valid with the CDB value. LSB CDB wins if both CDBs carry the same tag, which is illegal; flag it with an assertion.
- **Wakeup.** Every busy entry compares `Qj`/`Qk` against both CDB tags each cycle. On a match it latches the result and clears the busy bit.
- **Readiness.** An entry is ready when it is busy and each operand is either not pending or matched by a CDB this cycle; a matched operand forwards the CDB value.
- **Select.** Choose the lowest-index ready entry. A freshly dispatched entry is never selected on the edge it is written.
- **Issue.** The selected entry's op, rob and operand values go to the `ALU_*` registers with `ALU_sgn`=1. The entry frees on the same edge. If nothing is ready, `ALU_sgn`=0 and the payload holds its previous value.
- **Full.** `RS_full` is registered and equals 1 when the post-edge free count is ≤1. This gives the dispatcher one cycle of slack.
- **Invalid dispatch.** A dispatch with no free entry is dropped (assertion).
- **Priority.** `rst` > `ROB_clear` > normal. On `ROB_clear`, all busy bits clear, `ALU_sgn`=0 and `RS_full`=0, and any dispatch that cycle is ignored.
- **`rdy` low.** Every register holds, including `ALU_*`. `ROB_clear` is also ignored.

## Timing
- Reset values: `ALU_sgn`=0, `ALU_opcode`=0, `ALU_ROB_name`=0, `ALU_lhs`=0, `ALU_rhs`=0, `RS_full`=0; all entries free.
- **Dispatch latency.** An entry dispatched at edge t with ready operands issues at edge t+1. The ALU result appears on the ALU CDB during the cycle following t+1.
- **Back-to-back dependency.** A consumer waiting on that tag wakes and issues at edge t+2 via CDB forwarding, with no extra bubble.
- **Throughput.** One issue per cycle; one dispatch per cycle, concurrent with issue.
- **Simultaneous dispatch and issue.** A dispatch and an issue that free/claim the same index in one cycle cannot conflict: allocation uses pre-edge free bits, so the freed index is reusable from the next edge.
- **Reset mid-operation.** Reset is asynchronous; all outputs drop to reset values immediately.

## Structure
- Shared defines (existing defines file): ALU opcode macros, `` `ROBID ``, `` `True ``/`` `False ``.
- Add `` `RS_SIZE `` and `` `RSID `` (index range) to the shared defines.
- One sub-module, `rs_pick`: parameterised lowest-index priority encoder producing `found` and `idx`. Instantiate it twice: free slot and ready slot.

## Test plan
- **Basic issue.** Dispatch `ADD`, Vj=5, Vk=7, both ready, tag 3 at edge 0 → edge 1: `ALU_sgn`=1, lhs=5, rhs=7, `ALU_ROB_name`=3.
- **Dependency chain.**
  - Dispatch A (`ADDI` 1+2, tag 1), then B (`ADD`, Qj=1, Vk=10, tag 2) next cycle.
  - A issues; ALU CDB broadcasts tag 1 = 3.
  - B issues the following edge with lhs=3, rhs=10.
- **Load forwarding.** Entry waits on Qk=6. Assert LSB CDB tag 6 = 0xDEADBEEF → entry issues that edge with rhs=0xDEADBEEF. The entry is never issued before the broadcast.
- **Dispatch-cycle capture and fill.**
  - Dispatch with Qj=4 while ALU CDB carries tag 4 = 9 → entry stored ready, issues next edge with lhs=9.
  - Fill 15 of 16 entries with blocked ops → `RS_full`=1.
- **Flush.** Fill 5 blocked entries, assert `ROB_clear` with `DP_sgn`=1 → next edge: all free, `ALU_sgn`=0, the dispatched op is absent, `RS_full`=0.
- **Freeze and reset.**
  - With an issue pending, drop `rdy` for 3 cycles → `ALU_*` unchanged, no entry freed. Raise `rdy` → issue resumes.
  - Pulse `rst` mid-cycle → outputs zero asynchronously.
